// File: rtl/sfx_pkg.sv
// Shared types and the note-period table for the sound-effect sequencer.
//   sfx_id_e     : effect identifier. The numeric value is also the priority.
//   sfx_state_e  : sequencer FSM states.
//   NOTES        : number of notes in every effect.
//   note_period  : divider period for (effect, note). 0 means a rest.
//   period_max   : largest entry in the table, used for the width check.
package sfx_pkg;

    typedef enum logic [1:0] {
        SFX_NONE = 2'd0,
        SFX_DIR  = 2'd1,
        SFX_GOOD = 2'd2,
        SFX_BAD  = 2'd3
    } sfx_id_e;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } sfx_state_e;

    localparam int NOTES = 4;

    function automatic int unsigned note_period(sfx_id_e id, logic [1:0] idx);
        int unsigned p;
        p = 0;
        case (id)
            SFX_GOOD: case (idx)
                2'd0: p = 40;
                2'd1: p = 32;
                2'd2: p = 27;
                default: p = 20;
            endcase
            SFX_BAD: case (idx)
                2'd0: p = 60;
                2'd1: p = 80;
                2'd2: p = 100;
                default: p = 120;
            endcase
            SFX_DIR: p = (idx == 2'd0) ? 24 : 0;
            default: p = 0;
        endcase
        return p;
    endfunction

    function automatic int unsigned period_max();
        int unsigned m;
        m = 0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < NOTES; j++) begin
                if (note_period(sfx_id_e'(i), 2'(j)) > m)
                    m = note_period(sfx_id_e'(i), 2'(j));
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/tone_osc.sv
// Note oscillator: period divider plus square phase and sawtooth ramp.
//   clk, rst  : clock, synchronous active-high reset
//   clear     : restart the note (divider, phase and ramp to 0)
//   period    : divider period; 0 is a rest (divider held, no ticks)
//   wave_sel  : 0 = square, 1 = sawtooth
//   sample    : waveform value the registers take at the coming edge, so
//               the parent's output register shows a tick one cycle later
module tone_osc #(
    parameter int N     = 8,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [DIV_W-1:0] period,
    input  logic             wave_sel,
    output logic [N-1:0]     sample
);

    logic [DIV_W-1:0] div;
    logic             phase;
    logic [N-1:0]     ramp;
    logic             tick;
    logic             phase_nxt;
    logic [N-1:0]     ramp_nxt;

    always_comb begin
        tick      = (period != '0) && (div == period - DIV_W'(1));
        phase_nxt = phase;
        ramp_nxt  = ramp;
        if (clear) begin
            phase_nxt = 1'b0;
            ramp_nxt  = '0;
        end else if (tick) begin
            phase_nxt = ~phase;
            ramp_nxt  = ramp + N'(1);
        end
        sample = wave_sel ? ramp_nxt : {N{phase_nxt}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div   <= '0;
            phase <= 1'b0;
            ramp  <= '0;
        end else begin
            phase <= phase_nxt;
            ramp  <= ramp_nxt;
            if (clear || period == '0 || tick)
                div <= '0;
            else
                div <= div + DIV_W'(1);
        end
    end

endmodule

// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: turns game event edges into four-note effects.
//   clk, rst      : clock, synchronous active-high reset
//   goodColl_i    : rising edge starts the GOOD effect
//   badColl_i     : rising edge starts the BAD effect (highest priority)
//   dirChange_i   : rising edge starts the DIR effect (lowest priority)
//   wave_sel_i    : 0 = square, 1 = sawtooth
//   mute_i        : zero the output; the sequence keeps running
//   busy_o        : high while an effect plays
//   soundOut      : registered N-bit DAC sample
module sfx_sequencer
    import sfx_pkg::*;
#(
    parameter int N           = 8,
    parameter int DIV_W       = 16,
    parameter int NOTE_CYCLES = 1000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         goodColl_i,
    input  logic         badColl_i,
    input  logic         dirChange_i,
    input  logic         wave_sel_i,
    input  logic         mute_i,
    output logic         busy_o,
    output logic [N-1:0] soundOut
);

    localparam int DUR_W = (NOTE_CYCLES > 1) ? $clog2(NOTE_CYCLES) : 1;
    localparam int unsigned PERIOD_MAX = period_max();

    if ((PERIOD_MAX >> DIV_W) != 0) begin : g_period_check
        $error("note period table does not fit DIV_W");
    end
    if (NOTE_CYCLES < 2) begin : g_note_check
        $error("NOTE_CYCLES must be at least 2");
    end

    sfx_state_e       state;
    sfx_id_e          cur_id;
    sfx_id_e          trig_id;
    logic [1:0]       idx;
    logic [DUR_W-1:0] dur;
    logic [2:0]       hist;      // {bad, good, dir} from the previous cycle
    logic [2:0]       rise;
    logic             start;
    logic             note_end;
    logic [DIV_W-1:0] period;
    logic [N-1:0]     sample;

    assign rise = {badColl_i, goodColl_i, dirChange_i} & ~hist;

    always_comb begin
        trig_id = SFX_NONE;
        if (rise[2])      trig_id = SFX_BAD;
        else if (rise[1]) trig_id = SFX_GOOD;
        else if (rise[0]) trig_id = SFX_DIR;
    end

    // Equal priority also restarts, so a repeated event replays from note 0.
    assign start    = (trig_id != SFX_NONE) && (state == IDLE || trig_id >= cur_id);
    assign note_end = (state == PLAY) && (dur == DUR_W'(NOTE_CYCLES - 1));
    assign period   = (state == PLAY) ? DIV_W'(note_period(cur_id, idx)) : '0;

    tone_osc #(.N(N), .DIV_W(DIV_W)) u_osc (
        .clk      (clk),
        .rst      (rst),
        .clear    (start || note_end),
        .period   (period),
        .wave_sel (wave_sel_i),
        .sample   (sample)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy_o <= 1'b0;
            cur_id <= SFX_NONE;
            idx    <= '0;
            dur    <= '0;
            hist   <= 3'b111;   // a level held high across reset is not an edge
        end else begin
            hist <= {badColl_i, goodColl_i, dirChange_i};
            if (start) begin
                state  <= PLAY;
                busy_o <= 1'b1;
                cur_id <= trig_id;
                idx    <= '0;
                dur    <= '0;
            end else if (state == PLAY) begin
                if (note_end) begin
                    dur <= '0;
                    idx <= idx + 2'd1;
                    if (idx == 2'(NOTES - 1)) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end else begin
                    dur <= dur + DUR_W'(1);
                end
            end
        end
    end

    // Every entry to IDLE coincides with an oscillator clear, so the sample
    // is already 0 there; the gate covers rests, mute and idle.
    always_ff @(posedge clk) begin
        if (rst)
            soundOut <= '0;
        else if (mute_i || state == IDLE || period == '0)
            soundOut <= '0;
        else
            soundOut <= sample;
    end

endmodule

// File: tb/tb_sfx_sequencer.sv
// Bench for sfx_sequencer: directed scenarios followed by random event
// traffic, each cycle compared against an effect-level reference model.
module tb_sfx_sequencer;

    localparam int N     = 8;
    localparam int DIV_W = 16;
    localparam int NC    = 200;
    localparam int NOTES = 4;

    logic clk = 1'b0;
    logic rst, good, bad, dir, ws, mute;
    logic busy;
    logic [N-1:0] snd;

    always #5 clk = ~clk;

    sfx_sequencer #(.N(N), .DIV_W(DIV_W), .NOTE_CYCLES(NC)) dut (
        .clk         (clk),
        .rst         (rst),
        .goodColl_i  (good),
        .badColl_i   (bad),
        .dirChange_i (dir),
        .wave_sel_i  (ws),
        .mute_i      (mute),
        .busy_o      (busy),
        .soundOut    (snd)
    );

    // Period per [effect id][note]: NONE, DIR, GOOD, BAD.
    int ptab [4][4] = '{'{0, 0, 0, 0}, '{24, 0, 0, 0}, '{40, 32, 27, 20}, '{60, 80, 100, 120}};

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: is an effect playing, which one, and cycles since it started.
    bit          m_play = 0;
    int          m_id   = 0;
    int          m_t    = 0;
    logic [2:0]  m_hist = 3'b111;
    logic [31:0] e_busy = 0;
    logic [31:0] e_snd  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one cycle with the current inputs, then check the outputs.
    task automatic step();
        int tid, note, pos, p, ticks;
        bit start;
        if (rst) begin
            m_play = 0;
            m_hist = 3'b111;
            e_busy = 0;
            e_snd  = 0;
        end else begin
            tid = (bad && !m_hist[2]) ? 3 : (good && !m_hist[1]) ? 2 : (dir && !m_hist[0]) ? 1 : 0;
            start = (tid != 0) && (!m_play || tid >= m_id);
            e_snd = 0;
            if (m_play && !start && !mute) begin
                note = m_t / NC;
                pos  = m_t % NC;
                p    = ptab[m_id][note];
                // last cycle of a note restarts the oscillator
                if (pos != NC - 1 && p != 0) begin
                    ticks = (pos + 1) / p;
                    e_snd = ws ? (ticks % 256) : ((ticks % 2) ? 255 : 0);
                end
            end
            if (start) begin
                m_play = 1;
                m_id   = tid;
                m_t    = 0;
            end else if (m_play) begin
                if (m_t == NOTES * NC - 1) m_play = 0;
                else m_t++;
            end
            m_hist = {bad, good, dir};
            e_busy = m_play ? 1 : 0;
        end
        @(posedge clk);
        @(negedge clk);
        chk("busy", {31'b0, busy}, e_busy);
        chk("sound", {24'b0, snd}, e_snd);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int busy_len, first_ff;

    initial begin
        rst = 1; good = 1; bad = 1; dir = 1; ws = 0; mute = 0;
        @(negedge clk);

        // Reset with all inputs high, then release with them still high.
        steps(3);
        rst = 0;
        steps(50);
        chk("reset_busy", {31'b0, busy}, 0);
        chk("reset_sound", {24'b0, snd}, 0);
        good = 0; bad = 0; dir = 0;
        steps(5);

        // GOOD, square: busy length and first high sample.
        ws = 0;
        good = 1;
        step();
        chk("good_busy_rise", {31'b0, busy}, 1);
        good = 0;
        busy_len = 1;
        first_ff = -1;
        for (int i = 1; i < 1000; i++) begin
            step();
            if (first_ff < 0 && snd == 8'hFF) first_ff = i;
            if (!busy) break;
            busy_len++;
        end
        chk("good_busy_len", busy_len, 800);
        chk("good_first_ff", first_ff, 40);
        steps(10);

        // DIR, sawtooth: one stepping note then three rests.
        ws = 1;
        dir = 1;
        step();
        dir = 0;
        steps(820);

        // Preempt GOOD with BAD, then a dropped DIR during BAD.
        ws = 0;
        good = 1;
        step();
        good = 0;
        steps(99);
        bad = 1;
        step();
        chk("preempt_sound", {24'b0, snd}, 0);
        bad = 0;
        steps(300);
        dir = 1;
        step();
        dir = 0;
        steps(520);

        // Simultaneous GOOD and BAD.
        good = 1; bad = 1;
        step();
        good = 0; bad = 0;
        steps(850);

        // Mute during GOOD, then reset mid-note.
        good = 1;
        step();
        good = 0;
        steps(100);
        mute = 1;
        steps(100);
        mute = 0;
        steps(50);
        rst = 1;
        step();
        chk("midreset_busy", {31'b0, busy}, 0);
        chk("midreset_sound", {24'b0, snd}, 0);
        rst = 0;
        steps(20);

        // Random event traffic.
        for (int i = 0; i < 8000; i++) begin
            if ($urandom_range(0, 149) == 0) good = ~good;
            if ($urandom_range(0, 299) == 0) bad  = ~bad;
            if ($urandom_range(0, 99)  == 0) dir  = ~dir;
            if ($urandom_range(0, 99)  == 0) ws   = ~ws;
            if ($urandom_range(0, 399) == 0) mute = ~mute;
            rst = ($urandom_range(0, 2999) == 0);
            step();
        end
        rst = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sfx_sequencer.md
Name: sfx_sequencer

Overview:
Parametrised successor of the game sound generator. It turns collision and direction events into short multi-note sound effects instead of a single tone, and it selects between square and sawtooth waveforms. It sits between the game-logic event pulses and the N-bit DAC pins. Events are prioritised: a higher-priority event preempts the effect that is playing.

Parameters:
N, 8, DAC output width in bits.
DIV_W, 16, width of the note-period divider counter.
NOTE_CYCLES, 1000000, clock cycles per note; must be >= 2.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
goodColl_i  input  1  good-collision level; rising edge triggers SFX_GOOD
badColl_i  input  1  bad-collision level; rising edge triggers SFX_BAD
dirChange_i  input  1  direction-change level; rising edge triggers SFX_DIR
wave_sel_i  input  1  0 = square, 1 = sawtooth; sampled every cycle
mute_i  input  1  forces soundOut to 0; the sequence keeps running
busy_o  output  1  high while an effect is playing
soundOut  output  N  registered DAC sample

Behaviour:
- Reset, synchronous active-high, clk only:
  - state IDLE; busy_o=0; soundOut=0; divider, phase, ramp, note index and duration counter all 0.
  - Edge-detect history registers reset to 1, so an input held high through reset does not trigger.
- Edge detect: trigger when input=1 and its history register=0; history is updated every cycle.
- Priority encode: BAD(3) > GOOD(2) > DIR(1) > NONE(0).
- FSM, state IDLE:
  - On trigger id on cycle k, go to PLAY on the edge ending cycle k.
  - Load cur_id=id, idx=0, dur=0, divider=0, phase=0, ramp=0.
  - busy_o=1 from cycle k+1.
- FSM, state PLAY, normal progress:
  - dur increments each cycle.
  - When dur==NOTE_CYCLES-1: set dur=0, idx+=1, and clear divider, phase and ramp.
  - When idx==NOTES-1 and dur==NOTE_CYCLES-1: go to IDLE with busy_o=0.
  - busy_o is therefore high for exactly NOTES*NOTE_CYCLES cycles.
- FSM, state PLAY, new triggers:
  - A trigger with priority >= cur_id restarts the sequence with the new id, using the same loads as from IDLE.
  - A lower-priority trigger is dropped, not queued.
  - Simultaneous triggers resolve by priority.
- Note period P = sfx_pkg::note_period(cur_id, idx), DIV_W bits.
  - The divider counts 0..P-1 and asserts tick on count==P-1, then wraps to 0.
  - P==0 is a rest: divider held at 0, no ticks, waveform sample 0.
- Waveform:
  - Square: phase toggles on tick; sample = phase ? all-ones : 0.
  - Sawtooth: ramp (N bits) increments on tick and wraps 2^N-1 -> 0; sample = ramp.
  - wave_sel_i switching mid-note takes effect on the next cycle; phase and ramp keep running.
- Output timing:
  - soundOut <= (mute_i || state==IDLE || P==0) ? 0 : sample.
  - One register stage: the sample change caused by a tick is visible on the cycle after the tick.
- In IDLE the divider is frozen at 0 and soundOut=0.
- Period values must fit DIV_W; this is checked by an elaboration assertion on the table maximum.

Decomposition:
- sfx_pkg holds:
  - typedef enum logic [1:0] SFX_ID {SFX_NONE=0, SFX_DIR=1, SFX_GOOD=2, SFX_BAD=3}.
  - typedef enum logic {IDLE, PLAY}.
  - localparam NOTES=4.
  - function note_period(id, idx) returning the table below:
    - GOOD: 40, 32, 27, 20
    - BAD: 60, 80, 100, 120
    - DIR: 24, 0, 0, 0
    - NONE: all 0
- Sub-module tone_osc:
  - Contains the divider, phase and ramp.
  - Inputs: clk, rst, clear, period, wave_sel. Output: N-bit sample.
- The top level holds the edge detect, priority encoder, FSM, duration counter and output register.

Test Plan:
All tests use N=8 and NOTE_CYCLES=200.
1. Reset: hold rst with all inputs high, then release with inputs still high -> busy_o=0 and soundOut=8'h00 for 50 cycles; no trigger.
2. Good, square wave: goodColl_i pulse, wave_sel_i=0.
   - busy_o rises the next cycle and stays high exactly 800 cycles.
   - soundOut first becomes 8'hFF 40 cycles after busy_o rises and toggles every 40 cycles during note 0.
   - Note 1 toggles every 32 cycles.
3. Dir, sawtooth: dirChange_i pulse, wave_sel_i=1.
   - soundOut steps 0,1,2,… every 24 cycles for 200 cycles.
   - Then 0 for 600 cycles, then busy_o falls.
4. Preempt: goodColl_i pulse, then badColl_i at busy cycle 100.
   - Next cycle: period 60 applies, idx=0, soundOut=0.
   - busy_o stays high 800 cycles from the BAD trigger.
   - A dirChange_i pulse during BAD playback has no effect.
5. Simultaneous: goodColl_i and badColl_i rise together -> BAD sequence plays, with first toggle 60 cycles after busy_o rises.
6. Mute and mid-play reset:
   - mute_i=1 during GOOD playback -> soundOut=0 while busy_o still counts.
   - rst asserted mid-note -> next cycle busy_o=0 and soundOut=0.
